gp_register_file: RTL and testbench

GP_REGISTER_FILE -- requirements
Module: gp_register_file

---
 rtl/gp_register_file_pkg.sv | 23 ++
 rtl/gp_register_file_sweep_ctrl.sv | 66 ++++++
 rtl/gp_register_file.sv | 81 ++++++++
 tb/tb_gp_register_file.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gp_register_file_pkg.sv
// Shared types and constants for the general-purpose register file.
// Holds the flush FSM state enum, default sizes and the address-width helper.
package gp_register_file_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 16;

  // Smallest aw such that 2**aw >= depth.
  function automatic int calc_aw(input int depth);
    int aw;
    aw = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < depth) aw = i + 1;
    end
    return aw;
  endfunction

endpackage

// File: rtl/gp_register_file_sweep_ctrl.sv
// Flush controller: walks a clear index across every register, one per cycle,
// holding busy high for exactly DEPTH cycles.
module rf_sweep_ctrl
  import gp_register_file_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = calc_aw(DEF_DEPTH)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          flush_req,
  output logic          busy,
  output logic          sweep_en,
  output logic [AW-1:0] sweep_idx
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  sweep_state_t  r_state;
  sweep_state_t  w_state_next;
  logic [AW-1:0] r_sweep_idx;
  logic [AW-1:0] w_idx_next;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= IDLE;
      r_sweep_idx <= '0;
    end else begin
      r_state     <= w_state_next;
      r_sweep_idx <= w_idx_next;
    end
  end

  // flush_req is only looked at in IDLE, so requests during a sweep vanish.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_sweep_idx;
    case (r_state)
      IDLE: begin
        if (flush_req) begin
          w_state_next = SWEEP;
          w_idx_next   = '0;
        end
      end
      SWEEP: begin
        if (r_sweep_idx == LAST_IDX) begin
          w_state_next = IDLE;
          w_idx_next   = '0;
        end else begin
          w_idx_next = r_sweep_idx + 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_idx_next   = '0;
      end
    endcase
  end

  always_comb begin
    busy      = (r_state == SWEEP);
    sweep_en  = (r_state == SWEEP);
    sweep_idx = r_sweep_idx;
  end

endmodule

// File: rtl/gp_register_file.sv
// Two-read, one-write register file with same-cycle write bypass, optional
// hardwired-zero R0 / BAout gating on port A, and a sequential flush sweep.
module gp_register_file
  import gp_register_file_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int ZERO_R0 = 0,
  localparam int AW     = calc_aw(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  input  logic             BAout,
  input  logic             flush_req,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             busy
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_busy;
  logic             w_sweep_en;
  logic [AW-1:0]    w_sweep_idx;
  logic             w_wr_fire;
  logic [DEPTH-1:0] w_write;
  logic [DEPTH-1:0] w_clear;

  rf_sweep_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sweep_ctrl (
    .clk       (clk),
    .clr       (clr),
    .flush_req (flush_req),
    .busy      (w_busy),
    .sweep_en  (w_sweep_en),
    .sweep_idx (w_sweep_idx)
  );

  assign busy = w_busy;

  // Writes are dropped while sweeping, and never land in a hardwired R0.
  assign w_wr_fire = wr_en && !w_busy && !((ZERO_R0 != 0) && (wr_addr == '0));

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_decode
      assign w_write[gi] = w_wr_fire  && (wr_addr     == AW'(gi));
      assign w_clear[gi] = w_sweep_en && (w_sweep_idx == AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (clr || w_clear[i]) begin
        r_mem[i] <= '0;
      end else if (w_write[i]) begin
        r_mem[i] <= wr_data;
      end
    end
  end

  // Zeroing of index 0 is applied last so it overrides both storage and bypass.
  always_comb begin
    rd_data_a = r_mem[rd_addr_a];
    if (w_wr_fire && (rd_addr_a == wr_addr)) rd_data_a = wr_data;
    if ((rd_addr_a == '0) && ((ZERO_R0 != 0) || BAout)) rd_data_a = '0;
  end

  always_comb begin
    rd_data_b = r_mem[rd_addr_b];
    if (w_wr_fire && (rd_addr_b == wr_addr)) rd_data_b = wr_data;
    if ((rd_addr_b == '0) && (ZERO_R0 != 0)) rd_data_b = '0;
  end

endmodule

// File: tb/tb_gp_register_file.sv
// Directed bench for gp_register_file: one instance with storable R0 (dut0)
// and one with hardwired-zero R0 (dut1), driven by the same stimulus.
module tb_gp_register_file;

  localparam int W  = 32;
  localparam int D  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          clr, wr_en, BAout, flush_req;
  logic [AW-1:0] wr_addr, rd_addr_a, rd_addr_b;
  logic [W-1:0]  wr_data;
  logic [W-1:0]  rd_a0, rd_b0, rd_a1, rd_b1;
  logic          busy0, busy1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gp_register_file #(.WIDTH(W), .DEPTH(D), .ZERO_R0(0)) dut0 (
    .clk(clk), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .BAout(BAout), .flush_req(flush_req),
    .rd_data_a(rd_a0), .rd_data_b(rd_b0), .busy(busy0)
  );

  gp_register_file #(.WIDTH(W), .DEPTH(D), .ZERO_R0(1)) dut1 (
    .clk(clk), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .BAout(BAout), .flush_req(flush_req),
    .rd_data_a(rd_a1), .rd_data_b(rd_b1), .busy(busy1)
  );

  function automatic logic [W-1:0] fillv(input int i);
    return 32'hC0DE_0000 + i;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr = 0; wr_en = 0; BAout = 0; flush_req = 0;
    wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    clr = 1;
    tick();
    tick();
    clr = 0;
    for (int i = 0; i < D; i++) begin
      rd_addr_a = AW'(i); rd_addr_b = AW'(i);
      #1;
      checks++;
      if (rd_a0 !== 0 || rd_b0 !== 0 || rd_a1 !== 0 || rd_b1 !== 0) begin
        errors++;
        $display("FAIL reset_read[%0d]: got %h %h %h %h expected all 0", i, rd_a0, rd_b0, rd_a1, rd_b1);
      end
    end
    checks++;
    if (busy0 !== 0 || busy1 !== 0) begin
      errors++;
      $display("FAIL reset_busy: got %b %b expected 0", busy0, busy1);
    end
    $display("reset: all registers read, busy=%b", busy0);
  endtask

  task automatic test_write_read();
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEAD_BEEF;
    tick();
    wr_en = 0; rd_addr_a = 5; rd_addr_b = 5;
    #1;
    checks++;
    if (rd_a0 !== 32'hDEAD_BEEF || rd_b0 !== 32'hDEAD_BEEF || rd_a1 !== 32'hDEAD_BEEF || rd_b1 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL write_read_r5: got %h %h %h %h expected deadbeef", rd_a0, rd_b0, rd_a1, rd_b1);
    end
    BAout = 1;
    #1;
    checks++;
    if (rd_a0 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL baout_nonzero_addr: got %h expected deadbeef", rd_a0);
    end
    BAout = 0;
    $display("write R5 then read A=B=5: %h", rd_a0);
  endtask

  task automatic test_bypass();
    wr_en = 1; wr_addr = 3; wr_data = 32'h1234_5678; rd_addr_b = 3; rd_addr_a = 5;
    #1;
    checks++;
    if (rd_b0 !== 32'h1234_5678 || rd_b1 !== 32'h1234_5678 || rd_a0 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL bypass_r3: got B=%h/%h A=%h expected 12345678 / deadbeef", rd_b0, rd_b1, rd_a0);
    end
    tick();
    wr_en = 0;
    #1;
    checks++;
    if (rd_b0 !== 32'h1234_5678) begin
      errors++;
      $display("FAIL stored_r3: got %h expected 12345678", rd_b0);
    end
    $display("bypass write R3 read B same cycle: %h", rd_b0);
  endtask

  task automatic test_r0();
    wr_en = 1; wr_addr = 0; wr_data = 32'hFFFF_0000; rd_addr_a = 0; rd_addr_b = 0; BAout = 0;
    #1;
    checks++;
    if (rd_a0 !== 32'hFFFF_0000 || rd_b0 !== 32'hFFFF_0000 || rd_a1 !== 0 || rd_b1 !== 0) begin
      errors++;
      $display("FAIL r0_bypass: got %h %h %h %h expected ffff0000 ffff0000 0 0", rd_a0, rd_b0, rd_a1, rd_b1);
    end
    BAout = 1;
    #1;
    checks++;
    if (rd_a0 !== 0 || rd_b0 !== 32'hFFFF_0000) begin
      errors++;
      $display("FAIL r0_bypass_baout: got A=%h B=%h expected 0 ffff0000", rd_a0, rd_b0);
    end
    tick();
    wr_en = 0;
    #1;
    checks++;
    if (rd_a0 !== 0 || rd_b0 !== 32'hFFFF_0000 || rd_a1 !== 0 || rd_b1 !== 0) begin
      errors++;
      $display("FAIL r0_stored_baout1: got %h %h %h %h expected 0 ffff0000 0 0", rd_a0, rd_b0, rd_a1, rd_b1);
    end
    BAout = 0;
    #1;
    checks++;
    if (rd_a0 !== 32'hFFFF_0000 || rd_a1 !== 0) begin
      errors++;
      $display("FAIL r0_stored_baout0: got %h %h expected ffff0000 0", rd_a0, rd_a1);
    end
    wr_en = 1; wr_data = 32'hAAAA_AAAA;
    #1;
    checks++;
    if (rd_a1 !== 0 || rd_b1 !== 0 || rd_a0 !== 32'hAAAA_AAAA) begin
      errors++;
      $display("FAIL r0_zero_bypass: got %h %h / %h expected 0 0 / aaaaaaaa", rd_a1, rd_b1, rd_a0);
    end
    tick();
    wr_en = 0;
    #1;
    checks++;
    if (rd_a1 !== 0 || rd_b1 !== 0 || rd_b0 !== 32'hAAAA_AAAA) begin
      errors++;
      $display("FAIL r0_zero_stored: got %h %h / %h expected 0 0 / aaaaaaaa", rd_a1, rd_b1, rd_b0);
    end
    $display("R0 handling: dut0 A=%h dut1 A=%h", rd_a0, rd_a1);
  endtask

  task automatic fill_all();
    for (int i = 0; i < D; i++) begin
      wr_en = 1; wr_addr = AW'(i); wr_data = fillv(i);
      tick();
    end
    wr_en = 0;
  endtask

  task automatic test_flush();
    fill_all();
    flush_req = 1;
    tick();
    flush_req = 0;
    rd_addr_a = 15;
    for (int c = 0; c < D; c++) begin
      wr_en = 0; flush_req = (c == 5);
      if (c == 3 || c == 4) begin
        rd_addr_b = 7;
        if (c == 3) begin wr_en = 1; wr_addr = 7; wr_data = 32'h7777_7777; end
      end else begin
        rd_addr_b = AW'(c - 1);
      end
      #1;
      checks++;
      if (busy0 !== 1 || busy1 !== 1 || rd_a0 !== fillv(15) || rd_a1 !== fillv(15)) begin
        errors++;
        $display("FAIL sweep_cycle%0d: got busy=%b R15=%h expected busy=1 R15=%h", c, busy0, rd_a0, fillv(15));
      end
      checks++;
      if (c == 3 || c == 4) begin
        if (rd_b0 !== fillv(7)) begin
          errors++;
          $display("FAIL sweep_write_drop%0d: got %h expected %h", c, rd_b0, fillv(7));
        end
      end else if (c > 0) begin
        if (rd_b0 !== 0 || rd_b1 !== 0) begin
          errors++;
          $display("FAIL sweep_cleared%0d: got %h %h expected 0", c, rd_b0, rd_b1);
        end
      end else if (rd_b0 !== fillv(15)) begin
        errors++;
        $display("FAIL sweep_r15_b_cycle0: got %h expected %h", rd_b0, fillv(15));
      end
      tick();
    end
    wr_en = 0; flush_req = 0;
    checks++;
    if (busy0 !== 0 || busy1 !== 0) begin
      errors++;
      $display("FAIL sweep_end_busy: got %b %b expected 0", busy0, busy1);
    end
    for (int i = 0; i < D; i++) begin
      rd_addr_a = AW'(i); rd_addr_b = AW'(i);
      #1;
      checks++;
      if (rd_a0 !== 0 || rd_b0 !== 0 || rd_a1 !== 0 || rd_b1 !== 0) begin
        errors++;
        $display("FAIL post_sweep[%0d]: got %h %h expected 0", i, rd_a0, rd_b0);
      end
    end
    $display("flush sweep: 16 busy cycles checked, all registers cleared");
  endtask

  task automatic test_flush_with_write();
    wr_en = 1; wr_addr = 9; wr_data = 32'h9999_0009; flush_req = 1;
    tick();
    wr_en = 0; flush_req = 0; rd_addr_b = 9;
    #1;
    checks++;
    if (busy0 !== 1 || rd_b0 !== 32'h9999_0009) begin
      errors++;
      $display("FAIL flush_write_same: got busy=%b R9=%h expected 1 99990009", busy0, rd_b0);
    end
    for (int n = 0; n < 40 && busy0; n++) tick();
    checks++;
    if (busy0 !== 0 || rd_b0 !== 0) begin
      errors++;
      $display("FAIL flush_write_cleared: got busy=%b R9=%h expected 0 0", busy0, rd_b0);
    end
    $display("flush+write same cycle: R9 committed then cleared");
  endtask

  task automatic test_clr_abort();
    int n;
    fill_all();
    flush_req = 1;
    tick();
    flush_req = 0;
    repeat (4) tick();
    clr = 1;
    tick();
    clr = 0;
    checks++;
    if (busy0 !== 0 || busy1 !== 0) begin
      errors++;
      $display("FAIL clr_abort_busy: got %b %b expected 0", busy0, busy1);
    end
    for (int i = 0; i < D; i++) begin
      rd_addr_a = AW'(i); rd_addr_b = AW'(i);
      #1;
      checks++;
      if (rd_a0 !== 0 || rd_b0 !== 0) begin
        errors++;
        $display("FAIL clr_abort_read[%0d]: got %h %h expected 0", i, rd_a0, rd_b0);
      end
    end
    flush_req = 1;
    tick();
    flush_req = 0;
    n = 0;
    while (busy0 && n < 40) begin
      n++;
      tick();
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL fresh_sweep_len: got %0d busy cycles expected 16", n);
    end
    $display("clr during sweep: aborted, fresh sweep lasted %0d cycles", n);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_write_read();
    test_bypass();
    test_r0();
    test_flush();
    test_flush_with_write();
    test_clr_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
